// File: rtl/data_memory_sized.sv
// Single-port byte-addressed data memory for the MEM stage: byte/half/word access,
// load extension, selectable endianness, fault capture and post-reset zero fill.
module data_memory_sized #(
    parameter int ADDR_W     = 12,
    parameter bit BIG_ENDIAN = 1'b1,
    parameter bit INIT_ZERO  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        fault_clr,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        fault,
    output logic [31:0] fault_addr
);

    localparam int ROWS  = 2 ** (ADDR_W - 2);
    localparam int ROW_W = (ADDR_W > 2) ? ADDR_W - 2 : 1;

    typedef enum logic {ST_INIT, ST_IDLE} state_t;
    localparam state_t RESET_STATE = INIT_ZERO ? ST_INIT : ST_IDLE;

    state_t           state, state_next;
    logic [ROW_W-1:0] init_cnt;
    logic             init_last;
    logic             clr_en;
    logic             accept;
    logic             ready_q;
    logic             legal;
    logic             do_store;
    logic             do_load;
    logic [2:0]       nbytes;
    logic [ROW_W-1:0] row;
    logic [3:0]       lane_we;
    logic [7:0]       lane_wbyte [4];
    logic [7:0]       lane_rbyte [4];
    logic [31:0]      raw;
    logic [31:0]      load_val;

    // ---------------- init FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RESET_STATE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_INIT: if (init_last) state_next = ST_IDLE;
            ST_IDLE: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        clr_en = (state == ST_INIT);
        accept = req && ready_q;
    end

    assign init_last = (init_cnt == ROW_W'(ROWS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_cnt <= '0;
            ready_q  <= 1'b0;
        end else begin
            if (clr_en) init_cnt <= init_cnt + 1'b1;
            // Registered so ready stays low through reset even when init is skipped.
            ready_q <= (state_next == ST_IDLE);
        end
    end

    assign ready = ready_q;

    // ---------------- access decode ----------------
    // Memory is four byte banks indexed by addr[1:0]; every legal access hits one row.
    always_comb begin
        logic [1:0] off;
        logic [1:0] sel;
        // NOTE: every output of a combinational block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        case (size)
            2'b01:   nbytes = 3'd2;
            2'b10:   nbytes = 3'd4;
            default: nbytes = 3'd1;
        endcase

        legal = 1'b1;
        if (size == 2'b11)                      legal = 1'b0;
        if (size == 2'b01 && addr[0])           legal = 1'b0;
        if (size == 2'b10 && addr[1:0] != 2'b0) legal = 1'b0;
        if ((addr >> ADDR_W) != '0)             legal = 1'b0;

        do_store = accept && we && legal;
        do_load  = accept && !we;
        row      = addr[ROW_W+1:2];

        for (int b = 0; b < 4; b++) begin
            off = 2'(b) - addr[1:0];
            sel = BIG_ENDIAN ? 2'(nbytes - 3'd1 - {1'b0, off}) : off;
            lane_we[b]    = do_store && ({1'b0, off} < nbytes);
            lane_wbyte[b] = wdata[8*sel +: 8];
        end
    end

    genvar gb;
    for (gb = 0; gb < 4; gb++) begin : g_bank
        logic [7:0] mem [ROWS];

        // NOTE: the array has no reset branch; clearing is done by the init sequence,
        // which keeps this mappable onto RAM primitives.
        always_ff @(posedge clk) begin
            if (clr_en)           mem[init_cnt] <= 8'h00;
            else if (lane_we[gb]) mem[row]      <= lane_wbyte[gb];
        end

        assign lane_rbyte[gb] = mem[row];
    end

    // ---------------- load assembly and extension ----------------
    always_comb begin
        logic [1:0] src;
        raw = '0;
        for (int j = 0; j < 4; j++) begin
            src = BIG_ENDIAN ? 2'(addr[1:0] + nbytes - 3'd1 - 3'(j))
                             : 2'(addr[1:0] + 2'(j));
            raw[8*j +: 8] = (3'(j) < nbytes) ? lane_rbyte[src] : 8'h00;
        end
        case (size)
            2'b00:   load_val = {{24{sign_ext & raw[7]}}, raw[7:0]};
            2'b01:   load_val = {{16{sign_ext & raw[15]}}, raw[15:0]};
            default: load_val = raw;
        endcase
    end

    // ---------------- response and fault registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid     <= 1'b0;
            rdata      <= '0;
            fault      <= 1'b0;
            fault_addr <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples
            // pre-edge values regardless of statement order.
            rvalid <= do_load;
            if (do_load) rdata <= legal ? load_val : '0;
            // A new fault takes priority over a clear in the same cycle.
            if (accept && !legal) begin
                fault      <= 1'b1;
                fault_addr <= addr;
            end else if (fault_clr) begin
                fault <= 1'b0;
            end
        end
    end

endmodule

// File: doc/data_memory_sized.md
Name: data_memory_sized

Overview:
- Parametrised successor to the single-cycle processor's byte-array data memory.
- Single-port, byte-addressed, synchronous RAM serving the MEM stage.
- Supports byte, halfword and word accesses, with sign or zero extension on loads and selectable endianness.
- Detects misaligned and out-of-range accesses; zero-initialises itself after reset through an init state machine.

Parameters:
- ADDR_W, 12, byte-address bits used; DEPTH = 2**ADDR_W bytes (4096 default); minimum 2.
- BIG_ENDIAN, 1, 1 = byte at addr is word MSB (existing processor convention); 0 = little-endian.
- INIT_ZERO, 1, 1 = clear all memory after reset before accepting requests; 0 = skip init.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req  in  1  access request, sampled when ready=1
- we  in  1  1 = store, 0 = load
- size  in  2  00 byte, 01 half, 10 word, 11 reserved
- sign_ext  in  1  loads only: 1 sign-extend, 0 zero-extend
- addr  in  32  byte address
- wdata  in  32  store data; sub-word stores use the low bits
- fault_clr  in  1  clears sticky fault
- ready  out  1  block can accept req this cycle
- rdata  out  32  load result
- rvalid  out  1  one-cycle pulse: rdata valid
- fault  out  1  sticky: an illegal access occurred
- fault_addr  out  32  addr of the most recent faulting access

Behaviour:
- Clock is clk; reset is rst_n, asynchronous and active-low.
- Reset values: ready=0, rvalid=0, rdata=0, fault=0, fault_addr=0, state=INIT (INIT_ZERO=1) or IDLE (INIT_ZERO=0).
  - Memory array contents are not reset.
- State INIT:
  - Word counter starts at 0 and zeroes 4 bytes per cycle; ready=0; req is ignored.
  - After DEPTH/4 cycles, go to IDLE.
  - ready=1 on the cycle after the last clear.
  - rst_n asserting mid-INIT restarts the counter from 0.
- State IDLE:
  - ready=1 permanently; one transaction is accepted per cycle when req && ready.
- Legality of an accepted access:
  - Illegal when size=11.
  - Illegal when half with addr[0]=1, or word with addr[1:0]!=0.
  - Illegal when addr >= DEPTH (any bit of addr[31:ADDR_W] set).
- Legal store: the addressed bytes are written at the accepting edge. No rvalid.
- Legal load: on the next edge, rdata = extended lane data and rvalid=1 for exactly one cycle.
- Back-to-back accesses are allowed every cycle. A load issued the cycle after a store to the same bytes returns the new data.
- Byte lanes:
  - BIG_ENDIAN=1: word = {M[a],M[a+1],M[a+2],M[a+3]}; half = {M[a],M[a+1]}.
  - BIG_ENDIAN=0: byte order is reversed.
- Load extension: byte and half results are right-justified.
  - sign_ext=1 replicates bit 7 (byte) or bit 15 (half) upward.
  - sign_ext=0 fills with zeros.
  - sign_ext is ignored for word loads.
- Illegal access:
  - No memory write.
  - fault=1 and fault_addr=addr on the next edge.
  - An illegal load still pulses rvalid with rdata=0.
- fault_clr clears fault on the next edge; fault_addr holds its value.
  - If fault_clr and a new fault occur in the same cycle, the new fault wins: fault=1 and fault_addr updates.
- rdata holds its last value when rvalid=0.
- rst_n asserting mid-transaction: the pending rvalid is dropped and outputs take their reset values.

Test Plan:
- Reset then init (INIT_ZERO=1, ADDR_W=12) -> ready=0 for 1024 cycles, then ready=1; word load at 0x7FC -> rdata=0x00000000, rvalid high for 1 cycle.
- Word store 0x8F090008 @0x8, then byte loads @0x8..0xB, BIG_ENDIAN=1, sign_ext=1 -> 0xFFFFFF8F, 0x00000009, 0x00000000, 0x00000008; sign_ext=0 @0x8 -> 0x0000008F.
- Half store 0xABCD @0x12, then half load signed -> 0xFFFFABCD; word load @0x10 returns the old upper half with ABCD in the low half; with BIG_ENDIAN=0 the same store/load places CD at byte 0x12.
- Misaligned word load @0x6 -> rvalid=1, rdata=0, fault=1, fault_addr=0x6, memory unchanged.
- Store @0x1000 (ADDR_W=12) -> fault=1, fault_addr=0x1000; fault_clr with a simultaneous size=11 access -> fault stays 1.
- rst_n pulsed low at init cycle 500 -> ready stays 0 for a full 1024 cycles after release; a load on the cycle after a store to the same bytes returns the new data.
